serial_deserializer: RTL and testbench
======================================

// Module: serial_deserializer
// PURPOSE
//   Receive end of the team's serial bit stream: collects framed serial bits, one per si_valid
//   strobe, into a WIDTH-bit word and presents it on a valid/ready output port.
//   Pairs with the parallel-load shift register used as transmitter: mode 01 (shift-left,
//   MSB first) and mode 10 (shift-right, LSB first) are both decodable.
//   One-word output buffer; a sticky flag reports words dropped under backpressure.
// PARAMETERS
//   WIDTH  8  word length in bits; legal range WIDTH >= 2
// PORTS
//   clk         in   1      sole clock; all state changes on posedge clk
//   rst         in   1      synchronous, active-high reset
//   si          in   1      serial data bit
//   si_valid    in   1      si is sampled on this cycle
//   start       in   1      qualifies first bit of a frame (only meaningful when si_valid=1)
//   msb_first   in   1      1: first bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
//   dout        out  WIDTH  assembled word; stable while dout_valid=1
//   dout_valid  out  1      word available
//   dout_ready  in   1      consumer accepts dout when dout_valid && dout_ready
//   busy        out  1      frame in progress (state SHIFT)
//   frame_err   out  1      one-cycle pulse: frame aborted by a new start
//   overflow    out  1      sticky: a completed word was dropped
//   clear_ovf   in   1      clears overflow
// BEHAVIOUR
//   Reset (rst=1 at posedge): state IDLE, bit counter 0, shift reg 0, dout=0, dout_valid=0,
//     busy=0, frame_err=0, overflow=0. Reset mid-frame discards partial word and held word.
//   FSM IDLE: si_valid && start -> capture si as bit 1, latch msb_first for the frame, go SHIFT,
//     count=1. si_valid without start is ignored.
//   FSM SHIFT: each si_valid shifts si in; msb_first=1: sr <= {sr[WIDTH-2:0], si};
//     msb_first=0: sr <= {si, sr[WIDTH-1:1]}. Cycles without si_valid hold all state (gaps legal).
//   Completion: edge that samples bit WIDTH returns FSM to IDLE; count width $clog2(WIDTH+1).
//   Latency: completed word visible on dout with dout_valid=1 in the cycle after that edge.
//   Buffer: completed word loads dout if dout_valid=0, or if dout_valid && dout_ready this cycle
//     (back-to-back: dout_valid stays 1, no bubble). Otherwise word dropped, overflow <= 1,
//     dout unchanged.
//   dout_valid clears on handshake when no new word loads in the same cycle.
//   si_valid && start while in SHIFT: partial word discarded, frame_err pulses 1 cycle,
//     this bit restarts a new frame with count=1 and msb_first relatched.
//   msb_first changes mid-frame have no effect until the next start.
//   clear_ovf and a new overflow in the same cycle: set wins (overflow=1).
//   The bit completing a frame with start=1 is treated as a new frame start (abort rule applies).
// STRUCTURE
//   Shared package serial_pkg: FSM state encoding (ST_IDLE, ST_SHIFT) and bit-order constants
//     (ORDER_MSB_FIRST=1, ORDER_LSB_FIRST=0), also used by the transmitter side.
//   Single module, no sub-module: shift reg + counter + FSM + one output holding register.
// TESTING (WIDTH=8)
//   1. msb_first=1, bits 1,1,0,0,0,0,0,0, start on first -> dout=8'hC0, dout_valid 1 cycle after bit 8.
//   2. msb_first=0, same bits with 2-cycle gaps in si_valid -> dout=8'h03; busy=1 throughout frame.
//   3. dout_ready=0, frames 8'h11 then 8'h22 -> dout stays 8'h11, overflow=1; clear_ovf -> overflow=0.
//   4. dout_ready=1 on cycle 8'h22 completes while 8'h11 held -> dout=8'h22, dout_valid never drops, overflow=0.
//   5. start re-asserted on bit 4 -> frame_err single-cycle pulse; next 8 bits from that one yield a correct word.
//   6. rst asserted after 5 bits and while a word is held -> all outputs 0 next cycle; next frame decodes 8'hA5.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial link definitions for transmitter and receiver sides
//
// Purpose: FSM state encoding for the deserializer and the bit-order constants
//          that both ends of the serial link agree on.

package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic ORDER_MSB_FIRST = 1'b1;
    localparam logic ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-to-parallel receiver with one-word output buffer
//
// Purpose: collects WIDTH framed serial bits (one per si_valid) into a word and
//          presents it on a valid/ready port. Words completed while the buffer is
//          full and not being drained are dropped and flagged in sticky overflow.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   si, si_valid, start   serial bit, sample strobe, first-bit-of-frame marker
//   msb_first             bit order, latched at each frame start
//   dout, dout_valid      assembled word and its valid flag
//   dout_ready            consumer accepts the held word
//   busy                  frame in progress
//   frame_err             one-cycle pulse when a frame is aborted by a new start
//   overflow, clear_ovf   sticky dropped-word flag and its clear

module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    input  logic             start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_next;
    logic             r_msb;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;
    logic             r_overflow;

    logic             w_start_ev;
    logic             w_order;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;
    logic             w_abort;
    logic             w_can_load;

    // A start bit begins from an empty register with the newly presented bit
    // order, whether it opens a frame from IDLE or aborts one in progress.
    assign w_start_ev = si_valid && start;
    assign w_order    = w_start_ev ? msb_first : r_msb;
    assign w_base     = w_start_ev ? '0 : r_sr;
    assign w_shifted  = (w_order == ORDER_MSB_FIRST) ? {w_base[WIDTH-2:0], si}
                                                     : {si, w_base[WIDTH-1:1]};

    // The held word may be replaced when empty or when it is being drained on
    // this same edge, giving back-to-back words without a bubble.
    assign w_can_load = !r_dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_sr_next    = r_sr;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ev) begin
                    w_state_next = ST_SHIFT;
                    w_count_next = CW'(1);
                    w_sr_next    = w_shifted;
                end
            end
            ST_SHIFT: begin
                if (w_start_ev) begin
                    // Includes a start on what would have been the last bit.
                    w_abort      = 1'b1;
                    w_count_next = CW'(1);
                    w_sr_next    = w_shifted;
                end else if (si_valid) begin
                    w_sr_next = w_shifted;
                    if (r_count == LAST_IDX) begin
                        w_complete   = 1'b1;
                        w_state_next = ST_IDLE;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_sr         <= '0;
            r_msb        <= ORDER_MSB_FIRST;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_sr        <= w_sr_next;
            r_frame_err <= w_abort;
            if (w_start_ev) begin
                r_msb <= msb_first;
            end

            if (w_complete && w_can_load) begin
                r_dout       <= w_shifted;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (w_complete && !w_can_load) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state == ST_SHIFT);
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed scoreboard bench for serial_deserializer

module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       si;
    logic       si_valid;
    logic       start;
    logic       msb_first;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       frame_err;
    logic       overflow;
    logic       clear_ovf;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q[$];

    serial_deserializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .si         (si),
        .si_valid   (si_valid),
        .start      (start),
        .msb_first  (msb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        si       = b;
        si_valid = 1'b1;
        start    = st;
        tick();
        si_valid = 1'b0;
        start    = 1'b0;
        si       = 1'b0;
    endtask

    // Sends one full frame; checks busy after every bit and gap, and frame_err
    // after the first two bits.
    task automatic send_word(input logic [7:0] w, input logic msb, input int gap,
                             input logic rdy_last, input logic clr_last, input logic ferr_first);
        logic b;
        msb_first = msb;
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            if (i == 7) begin
                dout_ready = rdy_last;
                clear_ovf  = clr_last;
            end
            send_bit(b, i == 0);
            dout_ready = 1'b0;
            clear_ovf  = 1'b0;
            if (i == 0) chk("frame_err_first", frame_err, ferr_first);
            if (i == 1) chk("frame_err_second", frame_err, 1'b0);
            chk("busy_bit", busy, (i < 7));
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("busy_gap", busy, 1'b1);
                end
            end
        end
    endtask

    task automatic consume();
        int n = 0;
        while (!dout_valid && n < 20) begin
            tick();
            n++;
        end
        chk("consume_valid", dout_valid, 1'b1);
        chk("sb_nonempty", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) chk("dout", dout, sb_q.pop_front());
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("valid_after_accept", dout_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 8'h00);
        chk({tag, "_valid"}, dout_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ferr"}, frame_err, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    initial begin
        rst = 1'b1; si = 1'b0; si_valid = 1'b0; start = 1'b0;
        msb_first = 1'b1; dout_ready = 1'b0; clear_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // start-less bits in IDLE are ignored
        send_bit(1'b1, 1'b0);
        chk("idle_ignore_busy", busy, 1'b0);

        // 1: MSB first, 1100_0000, word visible right after the 8th bit edge
        send_word(8'hC0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("t1_latency_valid", dout_valid, 1'b1);
        sb_q.push_back(8'hC0);
        consume();

        // 2: LSB first with 2-cycle gaps, same bit sequence -> 8'h03
        send_word(8'h03, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(8'h03);
        consume();

        // 3: backpressure drops second word; clear; set wins over clear
        send_word(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(8'h11);
        send_word(8'h22, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("t3_held_dout", dout, 8'h11);
        chk("t3_ovf_set", overflow, 1'b1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t3_ovf_clr", overflow, 1'b0);
        send_word(8'h33, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("t3_set_wins", overflow, 1'b1);
        chk("t3_held_dout2", dout, 8'h11);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("t3_ovf_clr2", overflow, 1'b0);
        consume();

        // 4: held word drained on the very edge the next word completes
        send_word(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("t4_held_valid", dout_valid, 1'b1);
        chk("t4_held_dout", dout, sb_q.size() == 0 ? 8'h11 : 8'h00);
        sb_q.push_back(8'h22);
        send_word(8'h22, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("t4_valid_kept", dout_valid, 1'b1);
        chk("t4_ovf", overflow, 1'b0);
        consume();

        // 5: restart on bit 4 aborts the partial frame
        msb_first = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        chk("t5_ovf", overflow, 1'b0);
        sb_q.push_back(8'h5A);
        consume();

        // 6: reset with a word held and a partial frame in flight
        send_word(8'h3C, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("t6_held", dout, 8'h3C);
        msb_first = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(i[0], i == 0);
        chk("t6_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t6_rst");
        send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(8'hA5);
        consume();

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
